door_input_ctrl: RTL and testbench
==================================

DOOR_INPUT_CTRL -- requirements
Module: door_input_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 Parameter: DEBOUNCE_CYCLES, 500000, number of consecutive stable cycles before a level change is accepted (10 ms at 50 MHz); legal range 1..2^CNT_W-1.
REQ-003 Parameter: CNT_W, 20, debounce counter width in bits.
REQ-004 Port: clk  input  1  system clock, all logic on rising edge.
REQ-005 Port: reset  input  1  synchronous active-high reset.
REQ-006 Port: btn_j1  input  4  raw player-1 door buttons, active-high, asynchronous to clk; bit i = door i.
REQ-007 Port: btn_j2  input  4  raw player-2 door buttons, same encoding.
REQ-008 Port: round_clear  input  1  synchronous one-cycle pulse that discards both players' choices.
REQ-009 Port: posJ1  output  4  player-1 choice: bit3 = valid, bit2 = 0, bits1:0 = door index; feeds the data-memory player-1 IO register.
REQ-010 Port: posJ2  output  4  player-2 choice, same encoding.
REQ-011 Port: choice_pulse  output  2  one-cycle strobe; bit0 = new choice registered for player 1, bit1 = for player 2.

Function
REQ-012 Each of the 8 button bits SHALL pass through its own 2-flop synchronizer before any other logic.
REQ-013 Each synchronized bit SHALL have a debounced level, a CNT_W-bit counter and a registered copy of the debounced level used for edge detection.
REQ-014 Counter: cleared when the synchronized bit equals the debounced level; otherwise incremented; the debounced level SHALL toggle, and the counter clear, when the count reaches DEBOUNCE_CYCLES-1.
REQ-015 Press event: debounced level 1 while its registered copy is 0; releases SHALL produce no event; a held button SHALL produce exactly one event.
REQ-016 Per player, press events on several doors in the same cycle SHALL resolve to the lowest door index.
REQ-017 Per-player FSM states: IDLE (valid=0, index=00) and CHOSEN (valid=1, index=latched door).
REQ-018 IDLE -> CHOSEN on a press event: posJx <= {1'b1,1'b0,index} and the matching choice_pulse bit asserted, both in the cycle after the event.
REQ-019 Any state -> IDLE on round_clear: posJx <= 4'b0000 next cycle with no pulse; round_clear SHALL win over a press event in the same cycle (press discarded).
REQ-020 Latency: a raw level held stable from edge N SHALL appear on posJx and choice_pulse at edge N+DEBOUNCE_CYCLES+3.
REQ-021 Raw glitches shorter than DEBOUNCE_CYCLES cycles (after synchronization) SHALL change no output.
REQ-022 The two players SHALL be fully independent; simultaneous events on both SHALL update both in the same cycle.
REQ-023 posJx and choice_pulse SHALL be driven directly from flops.

Reset
REQ-024 Reset SHALL clear synchronizers, debounced levels, edge registers and counters to 0, put both FSMs in IDLE, and drive posJ1=posJ2=4'b0000, choice_pulse=2'b00 the cycle after reset is sampled.
REQ-025 Reset asserted mid-debounce or mid-choice SHALL abort all state; a button still held after reset release SHALL be treated as a new press once debounced.

Configuration
REQ-026 Macro PLAYER_LOCK_EN: when defined, press events in CHOSEN SHALL be ignored (first choice locked until round_clear or reset).
REQ-027 Without PLAYER_LOCK_EN, a press event in CHOSEN SHALL overwrite the index and assert the matching choice_pulse bit again, including a re-press of the same door.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Reset, btn_j1=4'b0100 held from edge 10 -> posJ1=4'b1010 and choice_pulse=2'b01 at edge 17 only; posJ2 stays 0.
REQ-029 btn_j2=4'b0001 high for 3 cycles then 0 -> posJ2 and choice_pulse remain 0.
REQ-030 btn_j1=4'b1010 pressed in the same cycle -> posJ1=4'b1001 (door 1 wins).
REQ-031 Player 1 CHOSEN door 2, then door 3 pressed -> with PLAYER_LOCK_EN posJ1 stays 4'b1010, no pulse; without it posJ1=4'b1011 with one pulse.
REQ-032 round_clear in the same cycle as a player-2 press event -> posJ2=4'b0000 next cycle, no pulse; button held thereafter produces no new event until released and pressed again.
REQ-033 Reset pulsed while btn_j1 bit0 has been held for 2 cycles -> outputs 0; button still held -> posJ1=4'b1000 at edge DEBOUNCE_CYCLES+3 after reset release.

Source files
------------

// File: rtl/door_input_ctrl.sv
// Door-choice input block: synchronizes and debounces both players' door buttons, then latches each player's choice.
// Build macro PLAYER_LOCK_EN locks a player's first choice until round_clear or reset.
module door_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_j1,
  input  logic [3:0] btn_j2,
  input  logic       round_clear,
  output logic [3:0] posJ1,
  output logic [3:0] posJ2,
  output logic [1:0] choice_pulse
);

  typedef enum logic {IDLE = 1'b0, CHOSEN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0] btn_raw;
  logic [7:0] press;
  logic [7:0] pos_all;
  logic [1:0] pulse_all;

  assign btn_raw = {btn_j2, btn_j1};

  genvar gi;
  generate
    // Bits 3:0 are player 1 doors, bits 7:4 are player 2 doors.
    for (gi = 0; gi < 8; gi++) begin : g_btn
      logic             sync1_reg;
      logic             sync2_reg;
      logic             deb_reg;
      logic             deb_q_reg;
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          deb_reg   <= 1'b0;
          deb_q_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          deb_q_reg <= deb_reg;
          if (sync2_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            deb_reg <= ~deb_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      end

      assign press[gi] = deb_reg & ~deb_q_reg;
    end

    for (gi = 0; gi < 2; gi++) begin : g_player
      logic [3:0] ev;
      logic [1:0] idx;
      state_t     state_reg;
      logic [3:0] pos_reg;
      logic       pulse_reg;

      assign ev = press[gi*4 +: 4];

      // Simultaneous presses resolve to the lowest door index.
      always_comb begin
        idx = 2'd3;
        if (ev[0])      idx = 2'd0;
        else if (ev[1]) idx = 2'd1;
        else if (ev[2]) idx = 2'd2;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          state_reg <= IDLE;
          pos_reg   <= 4'b0000;
          pulse_reg <= 1'b0;
        end else begin
          pulse_reg <= 1'b0;
          if (round_clear) begin
            state_reg <= IDLE;
            pos_reg   <= 4'b0000;
          end else begin
            case (state_reg)
              IDLE: begin
                if (|ev) begin
                  state_reg <= CHOSEN;
                  pos_reg   <= {2'b10, idx};
                  pulse_reg <= 1'b1;
                end
              end
              CHOSEN: begin
`ifndef PLAYER_LOCK_EN
                if (|ev) begin
                  pos_reg   <= {2'b10, idx};
                  pulse_reg <= 1'b1;
                end
`endif
              end
              default: state_reg <= IDLE;
            endcase
          end
        end
      end

      assign pos_all[gi*4 +: 4] = pos_reg;
      assign pulse_all[gi]      = pulse_reg;
    end
  endgenerate

  assign posJ1        = pos_all[3:0];
  assign posJ2        = pos_all[7:4];
  assign choice_pulse = pulse_all;

endmodule

// File: tb/tb_door_input_ctrl.sv
// Bench for door_input_ctrl (DEBOUNCE_CYCLES=4): stimulus table, timing sequences, and a random phase
// checked against a queue/run-length reference model.
module tb_door_input_ctrl;

  localparam int D = 4;
`ifdef PLAYER_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_j1;
  logic [3:0] btn_j2;
  logic       round_clear;
  logic [3:0] posJ1;
  logic [3:0] posJ2;
  logic [1:0] choice_pulse;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  door_input_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_j1      (btn_j1),
    .btn_j2      (btn_j2),
    .round_clear (round_clear),
    .posJ1       (posJ1),
    .posJ2       (posJ2),
    .choice_pulse(choice_pulse)
  );

  // Reference model: raw samples flow through a two-entry queue, a level is accepted after
  // D consecutive differing samples, and a rising accepted level becomes a press one cycle later.
  bit [7:0]   m_pipe[$];
  bit [7:0]   m_deb;
  bit [7:0]   m_rise;
  int         m_run[8];
  logic [3:0] m_pos[2];
  logic [1:0] m_pulse;

  always @(posedge clk) begin
    bit [7:0] v;
    bit [3:0] ev;
    int       first;
    if (reset) begin
      m_pipe  = {8'h00, 8'h00};
      m_deb   = '0;
      m_rise  = '0;
      for (int b = 0; b < 8; b++) m_run[b] = 0;
      m_pos[0] = 4'b0000;
      m_pos[1] = 4'b0000;
      m_pulse  = 2'b00;
    end else begin
      for (int p = 0; p < 2; p++) begin
        ev = m_rise[p*4 +: 4];
        m_pulse[p] = 1'b0;
        if (round_clear) begin
          m_pos[p] = 4'b0000;
        end else if (ev != 4'b0000 && !(LOCK && m_pos[p][3])) begin
          first = 3;
          for (int i = 3; i >= 0; i--) if (ev[i]) first = i;
          m_pos[p]   = {2'b10, 2'(first)};
          m_pulse[p] = 1'b1;
        end
      end
      m_pipe.push_back({btn_j2, btn_j1});
      v = m_pipe.pop_front();
      m_rise = '0;
      for (int b = 0; b < 8; b++) begin
        if (v[b] == m_deb[b]) begin
          m_run[b] = 0;
        end else begin
          m_run[b]++;
          if (m_run[b] == D) begin
            m_deb[b]  = ~m_deb[b];
            m_run[b]  = 0;
            m_rise[b] = m_deb[b];
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [3:0] j1;
    logic [3:0] j2;
    logic       clr;
    int         cycles;
    logic [3:0] e1;
    logic [3:0] e2;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int pcount;
    int hold;

    tbl[0]  = '{4'b0100, 4'b0000, 1'b0, 8, 4'b1010, 4'b0000};
    tbl[1]  = '{4'b0000, 4'b0000, 1'b0, 8, 4'b1010, 4'b0000};
    tbl[2]  = '{4'b1010, 4'b0000, 1'b0, 8, LOCK ? 4'b1010 : 4'b1001, 4'b0000};
    tbl[3]  = '{4'b0000, 4'b0001, 1'b0, 3, LOCK ? 4'b1010 : 4'b1001, 4'b0000};
    tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 8, LOCK ? 4'b1010 : 4'b1001, 4'b0000};
    tbl[5]  = '{4'b0000, 4'b0000, 1'b1, 1, 4'b0000, 4'b0000};
    tbl[6]  = '{4'b0000, 4'b0000, 1'b0, 2, 4'b0000, 4'b0000};
    tbl[7]  = '{4'b1000, 4'b0110, 1'b0, 8, 4'b1011, 4'b1001};
    tbl[8]  = '{4'b0000, 4'b0000, 1'b0, 8, 4'b1011, 4'b1001};
    tbl[9]  = '{4'b0001, 4'b0100, 1'b0, 8, LOCK ? 4'b1011 : 4'b1000, LOCK ? 4'b1001 : 4'b1010};
    tbl[10] = '{4'b0001, 4'b0100, 1'b1, 1, 4'b0000, 4'b0000};
    tbl[11] = '{4'b0001, 4'b0100, 1'b0, 8, 4'b0000, 4'b0000};
    tbl[12] = '{4'b0000, 4'b0000, 1'b0, 8, 4'b0000, 4'b0000};

    reset       = 1'b1;
    btn_j1      = 4'b0000;
    btn_j2      = 4'b0000;
    round_clear = 1'b0;
    step(2);
    check("reset_posJ1", posJ1, 4'b0000);
    check("reset_posJ2", posJ2, 4'b0000);
    check("reset_pulse", choice_pulse, 2'b00);
    $display("reset: posJ1=%b posJ2=%b pulse=%b", posJ1, posJ2, choice_pulse);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      btn_j1      = tbl[i].j1;
      btn_j2      = tbl[i].j2;
      round_clear = tbl[i].clr;
      step(1);
      round_clear = 1'b0;
      step(tbl[i].cycles - 1);
      check($sformatf("row%0d_posJ1", i), posJ1, tbl[i].e1);
      check($sformatf("row%0d_posJ2", i), posJ2, tbl[i].e2);
      $display("row %0d: j1=%b j2=%b clr=%b -> posJ1=%b posJ2=%b", i, tbl[i].j1, tbl[i].j2,
               tbl[i].clr, posJ1, posJ2);
    end

    // Exact press latency and single-cycle strobe.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
    btn_j1 = 4'b0100;
    for (int k = 1; k <= 9; k++) begin
      step(1);
      check($sformatf("lat_pulse_k%0d", k), choice_pulse, (k == D + 3) ? 2'b01 : 2'b00);
      check($sformatf("lat_posJ1_k%0d", k), posJ1, (k >= D + 3) ? 4'b1010 : 4'b0000);
      check($sformatf("lat_posJ2_k%0d", k), posJ2, 4'b0000);
    end
    $display("latency: posJ1=%b after %0d cycles", posJ1, 9);

    // Second press while a choice is held.
    btn_j1 = 4'b0000;
    step(8);
    btn_j1 = 4'b1000;
    pcount = 0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      pcount += int'(choice_pulse[0]);
      check("repress_no_p2_pulse", choice_pulse[1], 1'b0);
    end
    check("repress_pulses", pcount, LOCK ? 0 : 1);
    check("repress_posJ1", posJ1, LOCK ? 4'b1010 : 4'b1011);
    $display("repress: posJ1=%b pulses=%0d", posJ1, pcount);
    btn_j1 = 4'b0000;
    step(8);

    // round_clear coinciding with a player-2 press event.
    btn_j2 = 4'b0100;
    step(10);
    check("p2_first_posJ2", posJ2, 4'b1010);
    btn_j2 = 4'b0000;
    step(8);
    btn_j2 = 4'b0001;
    step(D + 2);
    round_clear = 1'b1;
    step(1);
    round_clear = 1'b0;
    check("clr_win_posJ2", posJ2, 4'b0000);
    check("clr_win_pulse", choice_pulse, 2'b00);
    pcount = 0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      pcount += int'(choice_pulse[1]);
    end
    check("clr_held_pulses", pcount, 0);
    check("clr_held_posJ2", posJ2, 4'b0000);
    btn_j2 = 4'b0000;
    step(8);
    btn_j2 = 4'b0001;
    step(8);
    check("clr_repress_posJ2", posJ2, 4'b1000);
    $display("clear race: posJ2=%b held pulses=%0d", posJ2, pcount);
    btn_j2 = 4'b0000;
    step(8);

    // Reset mid-debounce with the button still held afterwards.
    btn_j1 = 4'b0001;
    step(2);
    reset = 1'b1;
    step(1);
    check("midrst_posJ1", posJ1, 4'b0000);
    check("midrst_posJ2", posJ2, 4'b0000);
    check("midrst_pulse", choice_pulse, 2'b00);
    reset = 1'b0;
    for (int k = 1; k <= D + 4; k++) begin
      step(1);
      check($sformatf("postrst_posJ1_k%0d", k), posJ1, (k >= D + 3) ? 4'b1000 : 4'b0000);
      check($sformatf("postrst_pulse_k%0d", k), choice_pulse, (k == D + 3) ? 2'b01 : 2'b00);
    end
    $display("mid reset: posJ1=%b", posJ1);
    btn_j1 = 4'b0000;
    step(8);

    // Random segments against the reference model.
    for (int s = 0; s < 300; s++) begin
      hold = $urandom_range(1, 2 * D + 2);
      if ($urandom_range(0, 2) != 0) btn_j1 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) != 0) btn_j2 = 4'($urandom_range(0, 15));
      round_clear = ($urandom_range(0, 9) == 0);
      reset       = ($urandom_range(0, 39) == 0);
      for (int c = 0; c < hold; c++) begin
        step(1);
        round_clear = 1'b0;
        reset       = 1'b0;
        check("rnd_posJ1", posJ1, m_pos[0]);
        check("rnd_posJ2", posJ2, m_pos[1]);
        check("rnd_pulse", choice_pulse, m_pulse);
      end
      $display("seg %0d: j1=%b j2=%b hold=%0d posJ1=%b posJ2=%b", s, btn_j1, btn_j2, hold,
               posJ1, posJ2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
